// File: rtl/mac_vector_pkg.sv
// Register map, CTRL/STATUS bit positions, FSM states and byte-order helper for the vector MAC.
// Declarations only: no latency and no flow control of its own.
package mac_vector_pkg;

  localparam logic [4:0] REG_ADDR   = 5'd0;
  localparam logic [4:0] REG_START  = 5'd1;
  localparam logic [4:0] REG_CTRL   = 5'd2;
  localparam logic [4:0] REG_STATUS = 5'd3;
  localparam logic [4:0] REG_ACC0   = 5'd8;

  localparam int CTRL_TAPS_W     = 8;
  localparam int CTRL_SUB_BIT    = 8;
  localparam int CTRL_SAT_BIT    = 9;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_SAT_BIT  = 1;
  localparam int START_CH_LSB    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_MAC
  } state_t;

  // Memory words arrive big-endian; the datapath works little-endian.
  function automatic logic [31:0] endian_rev32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mac_vector_dp.sv
// Combinational signed multiply, add-or-subtract into a 32-bit accumulator, optional saturation.
// Zero latency; no flow control, the controlling FSM decides when the result is committed.
module mac_vector_dp #(
  parameter int COEF_W = 18
) (
  input  logic signed [31:0]       acc,
  input  logic signed [31:0]       a,
  input  logic signed [COEF_W-1:0] b,
  input  logic                     sub,
  input  logic                     sat,
  output logic [31:0]              acc_nxt,
  output logic                     clamp
);

  localparam int PW = 32 + COEF_W;
  localparam int SW = 34 + COEF_W;
  localparam logic signed [SW-1:0] MAXV = {{(SW-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-31){1'b1}}, {31{1'b0}}};

  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] acc_x;
  logic signed [SW-1:0] prod_x;
  logic signed [SW-1:0] sum;
  logic                 hi;
  logic                 lo;

  always_comb begin
    prod   = a * b;
    acc_x  = {{(SW-32){acc[31]}}, acc};
    prod_x = {{2{prod[PW-1]}}, prod};
    sum    = sub ? (acc_x - prod_x) : (acc_x + prod_x);
    hi     = sum > MAXV;
    lo     = sum < MINV;
    clamp  = sat & (hi | lo);
    if (clamp) acc_nxt = hi ? 32'h7fff_ffff : 32'h8000_0000;
    else       acc_nxt = sum[31:0];
  end

endmodule

// File: rtl/mac_vector_wb.sv
// Wishbone-programmed vector MAC: fetches one memory word per tap, multiplies by a ROM coefficient, accumulates into ACCn.
// One tap per (mem latency + 2) cycles; while busy every bus access except STATUS stalls with wb_ack low.
module mac_vector_wb
  import mac_vector_pkg::*;
#(
  parameter int TAPS        = 8,
  parameter int NCH         = 2,
  parameter int COEF_W      = 18,
  parameter int INDEX_W     = 9,
  parameter int COEF_STRIDE = 64,
  parameter int ADDR_STRIDE = 512
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wb_cyc,
  input  logic               wb_stb,
  input  logic               wb_we,
  input  logic [4:0]         wb_adr,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_valid,
  input  logic [31:0]        mem_rdata,
  output logic [INDEX_W-1:0] coef_idx,
  input  logic [COEF_W-1:0]  coef_data,
  output logic               busy
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t              state_q, state_d;
  logic [31:0]         addr_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [7:0]          taps_q;
  logic                sub_q, sat_q;
  logic                run_sub_q, run_sat_q;
  logic [7:0]          cnt_q;
  logic [CH_W-1:0]     ch_q;
  logic [CH_W-1:0]     ch_sel;
  logic [3:0]          start_ch;
  logic [31:0]         a_q;
  logic [COEF_W-1:0]   b_q;
  logic                sat_flag;
  logic [31:0]         acc_q [NCH];
  logic [31:0]         acc_nxt;
  logic                clamp;
  logic                wb_wr;
  logic                start_go;

  assign busy     = (state_q != ST_IDLE);
  assign mem_req  = (state_q == ST_REQ);
  assign mem_addr = addr_q;
  assign coef_idx = idx_q;
  assign wb_ack   = wb_cyc & wb_stb & (~busy | (wb_adr == REG_STATUS));
  assign wb_wr    = wb_ack & wb_we;
  assign start_go = wb_wr & (wb_adr == REG_START) & (taps_q != 8'd0);
  assign start_ch = wb_dat_i[START_CH_LSB +: 4];
  assign ch_sel   = (start_ch >= NCH) ? CH_W'(NCH - 1) : CH_W'(start_ch);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_go) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: if (mem_valid) state_d = ST_MAC;
      ST_MAC:  state_d = (cnt_q == 8'd1) ? ST_IDLE : ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  mac_vector_dp #(.COEF_W(COEF_W)) u_dp (
    .acc     (acc_q[ch_q]),
    .a       (a_q),
    .b       (b_q),
    .sub     (run_sub_q),
    .sat     (run_sat_q),
    .acc_nxt (acc_nxt),
    .clamp   (clamp)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      idx_q     <= '0;
      taps_q    <= 8'(TAPS);
      sub_q     <= 1'b0;
      sat_q     <= 1'b0;
      run_sub_q <= 1'b0;
      run_sat_q <= 1'b0;
      cnt_q     <= '0;
      ch_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sat_flag  <= 1'b0;
      for (int n = 0; n < NCH; n++) acc_q[n] <= '0;
    end else begin
      if (wb_wr) begin
        if (wb_adr == REG_ADDR) addr_q <= wb_dat_i;
        if (wb_adr == REG_CTRL) begin
          taps_q <= wb_dat_i[CTRL_TAPS_W-1:0];
          sub_q  <= wb_dat_i[CTRL_SUB_BIT];
          sat_q  <= wb_dat_i[CTRL_SAT_BIT];
        end
        if (wb_adr == REG_STATUS && wb_dat_i[STATUS_SAT_BIT]) sat_flag <= 1'b0;
        for (int n = 0; n < NCH; n++)
          if (wb_adr == REG_ACC0 + 5'(n)) acc_q[n] <= wb_dat_i;
      end
      // Operation parameters are frozen here so CTRL edits only affect the next vector.
      if (start_go) begin
        idx_q     <= wb_dat_i[INDEX_W-1:0];
        cnt_q     <= taps_q;
        run_sub_q <= sub_q;
        run_sat_q <= sat_q;
        ch_q      <= ch_sel;
      end
      if (state_q == ST_WAIT && mem_valid) begin
        a_q <= endian_rev32(mem_rdata);
        b_q <= coef_data;
      end
      if (state_q == ST_MAC) begin
        acc_q[ch_q] <= acc_nxt;
        cnt_q       <= cnt_q - 8'd1;
        addr_q      <= addr_q + 32'(ADDR_STRIDE);
        idx_q       <= idx_q + INDEX_W'(COEF_STRIDE);
        // Placed after the STATUS clear so a same-cycle clamp wins.
        if (clamp) sat_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    wb_dat_o = '0;
    case (wb_adr)
      REG_ADDR: wb_dat_o = addr_q;
      REG_CTRL: begin
        wb_dat_o[CTRL_TAPS_W-1:0] = taps_q;
        wb_dat_o[CTRL_SUB_BIT]    = sub_q;
        wb_dat_o[CTRL_SAT_BIT]    = sat_q;
      end
      REG_STATUS: begin
        wb_dat_o[STATUS_BUSY_BIT] = busy;
        wb_dat_o[STATUS_SAT_BIT]  = sat_flag;
      end
      default: begin
        for (int n = 0; n < NCH; n++)
          if (wb_adr == REG_ACC0 + 5'(n)) wb_dat_o = acc_q[n];
      end
    endcase
  end

endmodule

// File: tb/tb_mac_vector_wb.sv
// Bench for mac_vector_wb: directed vectors plus randomized ones checked against a longint arithmetic model.
// A memory responder with random latency serves mem_req; the coefficient ROM is modelled combinationally.
module tb_mac_vector_wb;

  localparam int NCH = 2;
  localparam logic [4:0] A_ADDR = 5'd0, A_START = 5'd1, A_CTRL = 5'd2, A_STATUS = 5'd3, A_ACC0 = 5'd8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [4:0]  wb_adr = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic [8:0]  coef_idx;
  logic [17:0] coef_data;
  logic        busy;

  logic        resp_valid = 1'b0, inj_valid = 1'b0;
  logic [31:0] resp_data = '0, inj_data = '0;
  assign mem_valid = resp_valid | inj_valid;
  assign mem_rdata = inj_valid ? inj_data : resp_data;

  int          n_checks = 0, n_err = 0;
  int          mem_mode = 0, coef_mode = 0, lat_min = 1, lat_max = 1;
  logic        resp_en = 1'b1, noise_en = 1'b0;
  logic [31:0] mem_const = '0;
  logic [17:0] coef_const = '0;
  logic [17:0] rom [512];
  int          busy_cnt = 0, req_cnt = 0;
  logic [31:0] addr_log[$], exp_addr[$];
  logic [8:0]  idx_log[$], exp_idx[$];
  logic [31:0] acc_m [NCH];
  logic        flag_m = 1'b0;

  mac_vector_wb #(.TAPS(8), .NCH(NCH), .COEF_W(18), .INDEX_W(9), .COEF_STRIDE(64), .ADDR_STRIDE(512)) dut (
    .clk(clk), .resetn(resetn), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .coef_idx(coef_idx), .coef_data(coef_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (coef_mode)
      0:       coef_data = coef_const;
      1:       coef_data = 18'(coef_idx);
      default: coef_data = rom[coef_idx];
    endcase
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (mem_req) req_cnt++;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (mem_mode == 0) ? mem_const : ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234);
  endfunction

  function automatic logic [17:0] coef_of(input logic [8:0] i);
    return (coef_mode == 0) ? coef_const : (coef_mode == 1) ? 18'(i) : rom[i];
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] start_word(input int ch, input logic [8:0] idx);
    return (32'(ch & 15) << 16) | 32'(idx);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory slave: one outstanding read, latency lat_min..lat_max cycles; optional junk
  // mem_valid pulses while no read is pending.
  initial begin : responder
    int lat;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      resp_valid = 1'b0;
      if (resp_en && mem_req) begin
        addr_log.push_back(mem_addr);
        idx_log.push_back(coef_idx);
        a = mem_addr;
        lat = int'($urandom_range(lat_max, lat_min));
        repeat (lat - 1) @(negedge clk);
        @(negedge clk);
        resp_valid = 1'b1;
        resp_data = mem_word(a);
      end else if (noise_en && $urandom_range(3, 0) == 0) begin
        resp_valid = 1'b1;
        resp_data = $urandom;
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat, output int waited, output logic busy_at_ack);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wdat;
    waited = 0;
    #1;
    while (!wb_ack && waited < 4000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!wb_ack) chk("wb_ack_timeout", 64'(wb_ack), 64'd1);
    rdat = wb_dat_o;
    busy_at_ack = busy;
    @(posedge clk);
    #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_wr(input logic [4:0] adr, input logic [31:0] d);
    logic [31:0] r; int w; logic b;
    wb_xfer(1'b1, adr, d, r, w, b);
  endtask

  task automatic wb_rd(input logic [4:0] adr, output logic [31:0] d);
    int w; logic b;
    wb_xfer(1'b0, adr, 32'd0, d, w, b);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic model_vec(input logic [31:0] addr0, input int taps, input logic sub, input logic sat,
                           input int ch, input logic [8:0] idx0);
    logic [31:0] ad;
    logic [8:0]  ix;
    longint      a, b, p, s, acc;
    int          c;
    ad = addr0; ix = idx0;
    c = (ch >= NCH) ? NCH - 1 : ch;
    exp_addr.delete(); exp_idx.delete();
    for (int k = 0; k < taps; k++) begin
      exp_addr.push_back(ad);
      exp_idx.push_back(ix);
      a = longint'($signed(bswap(mem_word(ad))));
      b = longint'($signed(coef_of(ix)));
      p = a * b;
      acc = longint'($signed(acc_m[c]));
      s = sub ? acc - p : acc + p;
      if (sat && s > 64'sd2147483647) begin
        acc_m[c] = 32'h7fff_ffff; flag_m = 1'b1;
      end else if (sat && s < -64'sd2147483648) begin
        acc_m[c] = 32'h8000_0000; flag_m = 1'b1;
      end else begin
        acc_m[c] = s[31:0];
      end
      ad = ad + 32'd512;
      ix = ix + 9'd64;
    end
  endtask

  task automatic vec_begin(input logic [31:0] addr0, input int taps, input logic sub, input logic sat,
                           input int ch, input logic [8:0] idx);
    wb_wr(A_ADDR, addr0);
    wb_wr(A_CTRL, {22'd0, sat, sub, 8'(taps)});
    model_vec(addr0, taps, sub, sat, ch, idx);
    addr_log.delete(); idx_log.delete();
    wb_wr(A_START, start_word(ch, idx));
  endtask

  task automatic vec_end();
    logic [31:0] d;
    wait_idle();
    chk("req_count", 64'(addr_log.size()), 64'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < addr_log.size(); k++) begin
      chk("mem_addr", 64'(addr_log[k]), 64'(exp_addr[k]));
      chk("coef_idx", 64'(idx_log[k]), 64'(exp_idx[k]));
    end
    for (int n = 0; n < NCH; n++) begin
      wb_rd(A_ACC0 + 5'(n), d);
      chk("acc", 64'(d), 64'(acc_m[n]));
    end
    wb_rd(A_STATUS, d);
    chk("status", 64'(d), {62'd0, flag_m, 1'b0});
  endtask

  task automatic run_vec(input logic [31:0] addr0, input int taps, input logic sub, input logic sat,
                         input int ch, input logic [8:0] idx);
    vec_begin(addr0, taps, sub, sat, ch, idx);
    vec_end();
  endtask

  initial begin : main
    logic [31:0] d;
    int          w, b0, r0;
    logic        ba;
    logic [8:0]  ci;
    logic [8:0]  seq [3];

    for (int i = 0; i < 512; i++) rom[i] = 18'($urandom);
    for (int n = 0; n < NCH; n++) acc_m[n] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    resetn = 1'b1;
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_coef_idx", 64'(coef_idx), 0);
    wb_rd(A_CTRL, d);   chk("rst_ctrl", 64'(d), 64'd8);
    wb_rd(A_ADDR, d);   chk("rst_addr", 64'(d), 0);
    wb_rd(A_STATUS, d); chk("rst_status", 64'(d), 0);
    wb_rd(A_ACC0, d);   chk("rst_acc0", 64'(d), 0);
    wb_rd(5'd5, d);     chk("unmapped_rd", 64'(d), 0);

    // Basic vector, reads issued while busy.
    mem_mode = 0; mem_const = 32'h0200_0000; coef_mode = 1;
    b0 = busy_cnt;
    vec_begin(32'h100, 8, 1'b0, 1'b0, 0, 9'd5);
    wb_xfer(1'b0, A_STATUS, 32'd0, d, w, ba);
    chk("status_rd_wait", 64'(w), 0);
    chk("status_busy_bit", 64'(d[0]), 1);
    wb_xfer(1'b0, A_ACC0, 32'd0, d, w, ba);
    chk("acc0_stalled", 64'(w > 0), 1);
    chk("acc0_ack_busy", 64'(ba), 0);
    chk("acc0_basic", 64'(d), 64'd3664);
    vec_end();
    chk("tap_period", 64'(busy_cnt - b0), 64'd24);

    // Index wrap.
    lat_max = 3;
    run_vec(32'h0, 3, 1'b0, 1'b0, 0, 9'd500);
    seq[0] = 9'd500; seq[1] = 9'd52; seq[2] = 9'd116;
    for (int k = 0; k < 3 && k < idx_log.size(); k++) chk("idx_wrap_seq", 64'(idx_log[k]), 64'(seq[k]));

    // Saturation on and off.
    mem_const = 32'h0100_0000; coef_mode = 0; coef_const = 18'h100;
    wb_wr(A_ACC0, 32'h7FFF_FFF0); acc_m[0] = 32'h7FFF_FFF0;
    run_vec(32'h200, 1, 1'b0, 1'b1, 0, 9'd0);
    wb_rd(A_ACC0, d);   chk("sat_acc0", 64'(d), 64'h7FFF_FFFF);
    wb_rd(A_STATUS, d); chk("sat_flag_set", 64'(d[1]), 1);
    wb_wr(A_ACC0, 32'h7FFF_FFF0); acc_m[0] = 32'h7FFF_FFF0;
    run_vec(32'h200, 1, 1'b0, 1'b0, 0, 9'd0);
    wb_rd(A_ACC0, d);   chk("wrap_acc0", 64'(d), 64'h8000_00F0);
    wb_rd(A_STATUS, d); chk("flag_kept", 64'(d[1]), 1);
    wb_wr(A_STATUS, 32'h2); flag_m = 1'b0;
    wb_rd(A_STATUS, d); chk("flag_cleared", 64'(d), 0);

    // Subtract into channel 1, then an out-of-range channel clamps to the last one.
    mem_const = 32'h0300_0000; coef_const = 18'h3FFFB;
    wb_wr(A_ACC0, 32'h1234); acc_m[0] = 32'h1234;
    wb_wr(A_ACC0 + 5'd1, 32'd100); acc_m[1] = 32'd100;
    run_vec(32'h300, 1, 1'b1, 1'b0, 1, 9'd0);
    wb_rd(A_ACC0 + 5'd1, d); chk("sub_acc1", 64'(d), 64'd115);
    wb_rd(A_ACC0, d);        chk("sub_acc0_kept", 64'(d), 64'h1234);
    run_vec(32'h300, 1, 1'b1, 1'b0, 9, 9'd0);
    wb_rd(A_ACC0 + 5'd1, d); chk("ch_clamp_acc1", 64'(d), 64'd130);

    // taps == 0 must not start anything.
    wb_wr(A_CTRL, 32'd0);
    ci = coef_idx; r0 = req_cnt;
    wb_wr(A_START, start_word(0, 9'h55));
    repeat (3) @(negedge clk);
    chk("taps0_busy", 64'(busy), 0);
    chk("taps0_req", 64'(req_cnt - r0), 0);
    chk("taps0_idx", 64'(coef_idx), 64'(ci));

    // Randomized vectors, including 32-bit address wrap and junk mem_valid outside WAIT.
    mem_mode = 1; coef_mode = 2; lat_min = 1; lat_max = 4; noise_en = 1'b1;
    run_vec(32'hFFFF_FE00, 3, 1'b0, 1'b0, 0, 9'd7);
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(2, 0) == 0)
        for (int n = 0; n < NCH; n++) begin
          acc_m[n] = $urandom;
          wb_wr(A_ACC0 + 5'(n), acc_m[n]);
        end
      if ($urandom_range(3, 0) == 0) begin
        wb_wr(A_STATUS, 32'h2);
        flag_m = 1'b0;
      end
      run_vec(($urandom_range(3, 0) == 0) ? 32'hFFFF_FC00 : $urandom, int'($urandom_range(6, 1)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), 9'($urandom));
    end

    // Reset while waiting on memory, then a stale mem_valid.
    noise_en = 1'b0; resp_en = 1'b0;
    wb_wr(A_ACC0, 32'hABCD); wb_wr(A_ACC0 + 5'd1, 32'h1357);
    wb_wr(A_ADDR, 32'h40);
    wb_wr(A_CTRL, 32'h4);
    wb_wr(A_START, start_word(0, 9'd3));
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 1);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 0);
    resetn = 1'b1;
    r0 = req_cnt;
    @(negedge clk);
    inj_valid = 1'b1; inj_data = 32'h0100_0000;
    @(negedge clk);
    inj_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_req", 64'(req_cnt - r0), 0);
    chk("post_rst_busy", 64'(busy), 0);
    chk("post_rst_mem_addr", 64'(mem_addr), 0);
    chk("post_rst_coef_idx", 64'(coef_idx), 0);
    wb_rd(A_ACC0, d);        chk("post_rst_acc0", 64'(d), 0);
    wb_rd(A_ACC0 + 5'd1, d); chk("post_rst_acc1", 64'(d), 0);
    wb_rd(A_CTRL, d);        chk("post_rst_ctrl", 64'(d), 64'd8);
    wb_rd(A_STATUS, d);      chk("post_rst_status", 64'(d), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
